// File: rtl/inst_fetch.sv
// inst_fetch - instruction fetch stage sitting behind the scheduler PC.
//
// Reads the current PC and issues one instruction-memory read at a time.
// Each issue pulses inc_pc so the PC advances on the next edge. Returned
// words are buffered with their fetch addresses in a small FIFO, which
// feeds decode over a valid/ready handshake. A flush throws away every
// buffered word and any response still in flight, so fetch can restart
// from a reloaded PC.
//
// Optional feature: define FETCH_BYPASS_EN to let a response flow straight
// from imem_rdata to inst_* in the same cycle whenever the FIFO is empty.
// Without it, a response shows up on inst_* one cycle after imem_rvalid.
//
// Parameters:
//   ADDR_W      instruction address width (defaults to `INSTMEM_ADDR_WIDTH)
//   INST_W      instruction word width
//   FIFO_DEPTH  buffered instructions, power of two, >= 2
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   run          in   fetch enable; an in-flight request still completes
//   flush        in   discard FIFO contents and any pending response
//   pc_addr      in   current PC value
//   inc_pc       out  one-cycle pulse, PC advances on the next edge
//   imem_req     out  read request, one cycle per fetch
//   imem_addr    out  read address, valid while imem_req=1
//   imem_rvalid  in   read data valid, at least one cycle after imem_req
//   imem_rdata   in   read data
//   inst_valid   out  FIFO head valid
//   inst_ready   in   decode accepts the head on valid & ready
//   inst_data    out  head instruction word
//   inst_addr    out  head instruction address

`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 16
`endif

module inst_fetch #(
  parameter int ADDR_W     = `INSTMEM_ADDR_WIDTH,
  parameter int INST_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              inc_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [INST_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];

  logic              fifo_empty;
  logic              rsp_valid;
  logic              rsp_keep;
  logic              bypass;
  logic              inst_take;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  occ_next;
  logic              issue;

  assign fifo_empty = (count_q == '0);

  // A response only counts while a request is outstanding. It is kept
  // unless a flush lands in the same cycle.
  assign rsp_valid = (state_q == ST_WAIT) & imem_rvalid;
  assign rsp_keep  = rsp_valid & ~flush;

  // inst_data/inst_addr are forced to zero whenever nothing is valid, so
  // the FIFO storage itself needs no reset.
`ifdef FETCH_BYPASS_EN
  assign bypass     = fifo_empty & rsp_keep;
  assign inst_valid = ~fifo_empty | bypass;
  assign inst_data  = ~fifo_empty ? data_mem_q[rd_ptr_q] :
                      (bypass ? imem_rdata : '0);
  assign inst_addr  = ~fifo_empty ? addr_mem_q[rd_ptr_q] :
                      (bypass ? req_addr_q : '0);
`else
  assign bypass     = 1'b0;
  assign inst_valid = ~fifo_empty;
  assign inst_data  = inst_valid ? data_mem_q[rd_ptr_q] : '0;
  assign inst_addr  = inst_valid ? addr_mem_q[rd_ptr_q] : '0;
`endif

  // A bypassed word that decode takes this cycle never enters the FIFO.
  assign inst_take = inst_valid & inst_ready;
  assign fifo_pop  = inst_take & ~fifo_empty;
  assign fifo_push = rsp_keep & ~(bypass & inst_ready);
  assign occ_next  = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // Gate issue with reset_n so the request outputs drop as soon as reset
  // asserts, not on the next edge. The rsp_valid term lets a new request
  // go out in the same cycle the previous one returns.
  assign issue = reset_n & run & ~flush &
                 (occ_next < CNT_W'(FIFO_DEPTH)) &
                 ((state_q == ST_IDLE) | rsp_valid);

  assign imem_req  = issue;
  assign inc_pc    = issue;
  assign imem_addr = issue ? pc_addr : '0;

  // Next-state logic. On a flush with nothing returned yet, park in DROP
  // so the stale response is swallowed when it finally arrives.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    if (issue) begin
      req_addr_d = pc_addr;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          state_d = issue ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!flush && imem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a
  // power of two. A flush empties the FIFO, and any pop in that cycle has
  // already been seen by decode.
  always_comb begin
    count_d  = occ_next;
    wr_ptr_d = wr_ptr_q + PTR_W'(fifo_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(fifo_pop);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata;
      addr_mem_q[wr_ptr_q] <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch - self-checking bench for inst_fetch in its default
// configuration (FETCH_BYPASS_EN undefined).
//
// A behavioural instruction memory answers every request after a
// programmable latency. The PC model advances on every inc_pc pulse.
// A scoreboard queue holds the {data, addr} pairs that decode should
// receive, in order, and is cleared on flush or reset.

module tb_inst_fetch;

  localparam int AW = 16;
  localparam int IW = 32;

  logic          clk;
  logic          reset_n;
  logic          run;
  logic          flush;
  logic [AW-1:0] pc_addr;
  logic          inc_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_addr;

  typedef struct {
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    logic run;
    logic flush;
    logic ready;
    logic expReq;
    logic expInc;
    logic expValid;
  } vec_t;

  exp_t          sbQ[$];
  vec_t          vecs[11];

  int            total;
  int            bad;
  int            popCount;
  int            reqCount;
  int            incCount;

  logic          snapReq;
  logic          snapInc;
  logic          snapValid;
  logic [AW-1:0] snapAddr;
  logic          sawDead;

  logic          outstanding;
  logic          outDropped;
  logic [AW-1:0] outAddr;
  int            outDelay;
  int            memLatency;
  logic          forceData;

  inst_fetch #(
    .ADDR_W(AW),
    .INST_W(IW),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .flush(flush),
    .pc_addr(pc_addr),
    .inc_pc(inc_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_addr(inst_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] dataFor(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    run        = v.run;
    flush      = v.flush;
    inst_ready = v.ready;
  endtask

  // One clock cycle. At the falling edge, snapshot the DUT, check any
  // pop against the scoreboard, and update the memory model. Just after
  // the rising edge, advance the PC and drive the memory response.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    snapReq   = imem_req;
    snapInc   = inc_pc;
    snapValid = inst_valid;
    snapAddr  = imem_addr;
    if (imem_req) begin
      reqCount++;
      checkOutput("req_addr_is_pc", 64'(imem_addr), 64'(pc_addr));
    end
    if (inc_pc) incCount++;
    if (inst_valid && inst_data == 32'hDEADBEEF) sawDead = 1'b1;
    if (inst_valid && inst_ready) begin
      popCount++;
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL pop_unexpected: got addr 0x%0h, want no instruction", inst_addr);
      end else begin
        e = sbQ.pop_front();
        checkOutput("pop_data", 64'(inst_data), 64'(e.data));
        checkOutput("pop_addr", 64'(inst_addr), 64'(e.addr));
      end
    end
    if (imem_rvalid && outstanding) begin
      if (!outDropped && !flush) sbQ.push_back('{data: imem_rdata, addr: outAddr});
      outstanding = 1'b0;
    end
    if (flush) begin
      sbQ.delete();
      if (outstanding) outDropped = 1'b1;
    end
    if (imem_req) begin
      outstanding = 1'b1;
      outAddr     = imem_addr;
      outDelay    = memLatency;
      outDropped  = 1'b0;
    end
    @(posedge clk);
    #1;
    if (snapInc) pc_addr = pc_addr + 16'd1;
    imem_rvalid = 1'b0;
    if (outstanding) begin
      if (outDelay <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = forceData ? 32'hDEADBEEF : dataFor(outAddr);
      end else begin
        outDelay--;
      end
    end
  endtask

  task automatic drain();
    run        = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b1;
    repeat (6) tick();
    checkOutput("drain_sb_empty", 64'(sbQ.size()), 64'd0);
    checkOutput("drain_valid_low", 64'(snapValid), 64'd0);
  endtask

  initial begin
    // Backpressure table: inputs {run, flush, ready} and expected
    // {imem_req, inc_pc, inst_valid} per cycle, starting idle and empty
    // with memory latency 1.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    total       = 0;
    bad         = 0;
    popCount    = 0;
    reqCount    = 0;
    incCount    = 0;
    sawDead     = 1'b0;
    outstanding = 1'b0;
    outDropped  = 1'b0;
    outAddr     = '0;
    outDelay    = 0;
    memLatency  = 1;
    forceData   = 1'b0;
    snapReq     = 1'b0;
    snapInc     = 1'b0;
    snapValid   = 1'b0;
    snapAddr    = '0;

    reset_n     = 1'b0;
    run         = 1'b0;
    flush       = 1'b0;
    pc_addr     = 16'h0010;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Test 1: reset values, then the first request goes out combinationally.
    #22;
    checkOutput("reset_ctrl_addr", 64'({imem_req, inc_pc, inst_valid, imem_addr, inst_addr}), 64'd0);
    checkOutput("reset_inst_data", 64'(inst_data), 64'd0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    run        = 1'b1;
    inst_ready = 1'b1;
    #1;
    checkOutput("first_req", 64'(imem_req), 64'd1);
    checkOutput("first_addr", 64'(imem_addr), 64'h10);
    checkOutput("first_inc", 64'(inc_pc), 64'd1);
    tick();
    drain();

    // Test 2: latency-1 streaming from PC 0, one instruction per cycle.
    pc_addr  = 16'h0000;
    popCount = 0;
    reqCount = 0;
    incCount = 0;
    run      = 1'b1;
    repeat (10) tick();
    checkOutput("stream_pops", 64'(popCount), 64'd8);
    checkOutput("stream_reqs", 64'(reqCount), 64'd10);
    checkOutput("stream_incs", 64'(incCount), 64'd10);
    drain();

    // Test 3: stall on a full FIFO and resume, table driven.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_req", i), 64'(snapReq), 64'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d_inc", i), 64'(snapInc), 64'(vecs[i].expInc));
      checkOutput($sformatf("vec%0d_valid", i), 64'(snapValid), 64'(vecs[i].expValid));
    end
    drain();

    // Test 4: flush in WAIT. The late 0xDEADBEEF response must be dropped,
    // and the next request must use the reloaded PC.
    memLatency = 3;
    forceData  = 1'b1;
    run        = 1'b1;
    tick();
    checkOutput("fl_issue", 64'(snapReq), 64'd1);
    flush = 1'b1;
    tick();
    checkOutput("fl_no_req", 64'(snapReq), 64'd0);
    checkOutput("fl_no_inc", 64'(snapInc), 64'd0);
    flush   = 1'b0;
    pc_addr = 16'h0040;
    tick();
    checkOutput("drop_no_req", 64'(snapReq), 64'd0);
    tick();
    checkOutput("drop_rvalid_no_req", 64'(snapReq), 64'd0);
    memLatency = 1;
    forceData  = 1'b0;
    tick();
    checkOutput("reload_req", 64'(snapReq), 64'd1);
    checkOutput("reload_addr", 64'(snapAddr), 64'h40);
    drain();
    checkOutput("dead_never_seen", 64'(sawDead), 64'd0);

    // Test 5: flush in the same cycle as a response that would fill the FIFO.
    memLatency = 2;
    inst_ready = 1'b0;
    run        = 1'b1;
    tick();
    checkOutput("f5_req0", 64'(snapReq), 64'd1);
    tick();
    checkOutput("f5_wait", 64'(snapReq), 64'd0);
    tick();
    checkOutput("f5_req1", 64'(snapReq), 64'd1);
    tick();
    checkOutput("f5_hold_valid", 64'(snapValid), 64'd1);
    flush = 1'b1;
    tick();
    checkOutput("f5_flush_req", 64'(snapReq), 64'd0);
    checkOutput("f5_flush_valid", 64'(snapValid), 64'd1);
    flush = 1'b0;
    tick();
    checkOutput("f5_empty_after", 64'(snapValid), 64'd0);
    checkOutput("f5_idle_issue", 64'(snapReq), 64'd1);
    drain();

    // Test 6: asynchronous reset while a request is outstanding.
    memLatency = 3;
    run        = 1'b1;
    tick();
    checkOutput("r6_issue", 64'(snapReq), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("r6_async_ctrl", 64'({imem_req, inc_pc, inst_valid, imem_addr, inst_addr}), 64'd0);
    checkOutput("r6_async_data", 64'(inst_data), 64'd0);
    sbQ.delete();
    outDropped = 1'b1;
    tick();
    checkOutput("r6_in_reset_req", 64'(snapReq), 64'd0);
    reset_n = 1'b1;
    run     = 1'b0;
    tick();
    tick();
    checkOutput("r6_rvalid_ignored", 64'(snapValid), 64'd0);
    tick();
    checkOutput("r6_no_push", 64'(snapValid), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
